// File: rtl/imem_loader_if.sv
// Byte-stream handshake feeding the instruction-memory loader.
// The stream source drives the master side and the loader implements the slave side.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes instruction memory,
// and releases the CPU reset only after the XOR checksum of the data bytes matches.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic                clk,
    input  logic                areset,
    imem_loader_if.slave        s_in,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wd,
    output logic                cpu_areset,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         words_loaded
);

    typedef enum logic [2:0] {
        ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
    } state_t;

    localparam logic [15:0] LP_MAX_WORDS = 16'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        w_in_ready;
    logic        w_accept;
    logic [15:0] w_hdr_n;
    logic [31:0] w_word;
    logic        w_word_end;
    logic        w_last_word;

    logic [7:0]  r_n_hi;
    logic [15:0] r_n;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    logic [7:0]  r_csum;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic        r_cpu_areset;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_words_loaded;

    assign w_accept      = s_in.in_valid && w_in_ready;
    assign s_in.in_ready = w_in_ready;
    assign w_hdr_n       = {r_n_hi, s_in.in_data};
    assign w_word        = {r_asm, s_in.in_data};
    assign w_word_end    = (r_byte_cnt == 2'd3);
    // words_loaded still holds the index of the word being completed
    assign w_last_word   = (r_words_loaded == (r_n - 16'd1));

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wd      = r_wd;
    assign cpu_areset   = r_cpu_areset;
    assign load_done    = r_done;
    assign load_error   = r_error;
    assign words_loaded = r_words_loaded;

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and ready decode
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_HDR_HI: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = ST_HDR_LO;
                end else begin
                    w_next = r_state;
                end
            end
            ST_HDR_LO: begin
                w_in_ready = 1'b1;
                if (!w_accept) begin
                    w_next = r_state;
                end else if (w_hdr_n > LP_MAX_WORDS) begin
                    w_next = ST_ERROR;
                end else if (w_hdr_n == 16'd0) begin
                    w_next = ST_CSUM;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_in_ready = 1'b1;
                if (w_accept && w_word_end && w_last_word) begin
                    w_next = ST_CSUM;
                end else begin
                    w_next = r_state;
                end
            end
            ST_CSUM: begin
                w_in_ready = 1'b1;
                if (!w_accept) begin
                    w_next = r_state;
                end else if (s_in.in_data == r_csum) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ERROR;
                end
            end
            ST_DONE:  w_next = ST_DONE;
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_ERROR;
        endcase
    end

    // Datapath: word assembly, checksum, registered write port and status flags
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_n_hi         <= 8'd0;
            r_n            <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_asm          <= 24'd0;
            r_csum         <= 8'd0;
            r_we           <= 1'b0;
            r_addr         <= BASE_ADDR;
            r_wd           <= 32'd0;
            r_cpu_areset   <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= 16'd0;
        end else begin
            r_we         <= 1'b0;
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERROR);
            r_cpu_areset <= (w_next != ST_DONE);
            if (w_accept) begin
                case (r_state)
                    ST_HDR_HI: r_n_hi <= s_in.in_data;
                    ST_HDR_LO: r_n    <= w_hdr_n;
                    ST_DATA: begin
                        r_asm      <= w_word[23:0];
                        r_csum     <= r_csum ^ s_in.in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_word_end) begin
                            r_we           <= 1'b1;
                            r_addr         <= BASE_ADDR + {14'd0, r_words_loaded, 2'd0};
                            r_wd           <= w_word;
                            r_words_loaded <= r_words_loaded + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 64;

    logic        clk;
    logic        areset;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_areset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_loader_if u_if ();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .areset       (areset),
        .s_in         (u_if),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wd      (imem_wd),
        .cpu_areset   (cpu_areset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: parse the whole stream by the format rules, queue expected writes,
    // and report how many bytes get consumed plus the final status (0 busy, 1 done, 2 error).
    task automatic model(input logic [7:0] s[$], output int consumed, output int status,
                         output int nw);
        int          n;
        logic [7:0]  x;
        consumed = 0; status = 0; nw = 0; x = 8'd0;
        if (s.size() < 2) begin
            consumed = s.size();
            return;
        end
        n = int'({s[0], s[1]});
        consumed = 2;
        if (n > MAXW) begin
            status = 2;
            return;
        end
        for (int i = 0; i < n * 4 && 2 + i < s.size(); i++) begin
            x = x ^ s[2 + i];
            consumed++;
        end
        for (int w = 0; w < n && 2 + 4 * w + 3 < s.size(); w++) begin
            exp_q.push_back({BASE + 32'(4 * w),
                             s[2 + 4 * w], s[3 + 4 * w], s[4 + 4 * w], s[5 + 4 * w]});
            nw++;
        end
        if (consumed == 2 + n * 4 && s.size() > consumed) begin
            status   = (s[consumed] == x) ? 1 : 2;
            consumed = consumed + 1;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'(BASE));
        chk("rst_imem_wd", 64'(imem_wd), 64'd0);
        chk("rst_cpu_areset", 64'(cpu_areset), 64'd1);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_load_error", 64'(load_error), 64'd0);
        chk("rst_words_loaded", 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        u_if.in_valid = 1'b0;
        areset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals();
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bubbles);
        if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                u_if.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.in_data  = b;
        chk("in_ready_while_loading", 64'(u_if.in_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic run_stream(input logic [7:0] s[$], input bit bubbles, input bit rst_first);
        int consumed, status, nw;
        if (rst_first) do_reset();
        model(s, consumed, status, nw);
        for (int i = 0; i < consumed; i++) send_byte(s[i], bubbles);
        // Trailing bytes must be refused once the loader is terminal
        for (int i = consumed; i < s.size(); i++) begin
            @(negedge clk);
            u_if.in_valid = 1'b1;
            u_if.in_data  = s[i];
            chk("ready_after_end", 64'(u_if.in_ready), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("load_done", 64'(load_done), 64'(status == 1));
        chk("load_error", 64'(load_error), 64'(status == 2));
        chk("cpu_areset", 64'(cpu_areset), 64'(status != 1));
        chk("words_loaded", 64'(words_loaded), 64'(nw));
        chk("in_ready_final", 64'(u_if.in_ready), 64'(status == 0));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    logic [7:0] good[$];
    logic [7:0] s[$];

    initial begin
        int consumed, status, nw;
        int n;
        logic [7:0] x;
        checks = 0;
        failures = 0;
        areset = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'd0;

        // Scoreboard monitor: every write strobe must match the oldest expected write
        fork
            forever begin
                @(posedge clk);
                #1;
                if (imem_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got %0h/%0h expected none",
                                 imem_addr, imem_wd);
                    end else begin
                        chk("imem_write", {imem_addr, imem_wd}, exp_q.pop_front());
                    end
                end
            end
        join_none

        good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        run_stream(good, 1'b0, 1'b1);

        s = good; s[10] = 8'h0F;
        run_stream(s, 1'b0, 1'b1);

        s = '{8'h00, 8'h00, 8'h00};
        run_stream(s, 1'b0, 1'b1);

        s = '{8'h00, 8'h00, 8'h05};
        run_stream(s, 1'b0, 1'b1);

        s = '{8'h00, 8'h41, 8'h01, 8'h02, 8'h03};
        run_stream(s, 1'b0, 1'b1);

        s = good; s.push_back(8'hAA); s.push_back(8'h55);
        run_stream(s, 1'b1, 1'b1);

        // Reset in the middle of the second word, then a complete reload
        do_reset();
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20};
        model(s, consumed, status, nw);
        for (int i = 0; i < consumed; i++) send_byte(s[i], 1'b0);
        u_if.in_valid = 1'b0;
        #3;
        areset = 1'b1;
        #1;
        check_reset_vals();
        chk("midload_writes_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        run_stream(good, 1'b0, 1'b0);

        // Largest accepted program, random contents and bubbles
        for (int t = 0; t < 6; t++) begin
            n = (t == 0) ? MAXW : int'($urandom_range(1, 10));
            s = '{8'(n >> 8), 8'(n)};
            x = 8'd0;
            for (int i = 0; i < n * 4; i++) begin
                s.push_back(8'($urandom));
                x = x ^ s[s.size() - 1];
            end
            if (t != 0 && $urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
            s.push_back(x);
            s.push_back(8'($urandom));
            run_stream(s, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS processor. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the write side of the instruction memory. It holds the processor in reset until the full program has loaded and its checksum has verified. It is the producer for the instruction-memory port that the processor only reads.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word.
- MAX_WORDS, 64: largest accepted word count. A header above this value is an error.
- clk  input  1  system clock; all state updates on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte. Decoded combinationally from state.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  32  byte address of the write (word-aligned).
- imem_wd  output  32  instruction word to write.
- cpu_areset  output  1  reset for the processor core. High until load succeeds.
- load_done  output  1  program loaded and checksum matched (sticky).
- load_error  output  1  count overflow or checksum mismatch (sticky).
- words_loaded  output  16  number of words written so far.

## Operation
- A byte is accepted only on a rising edge where in_valid && in_ready. in_valid may drop between bytes; bubbles have no effect.
- Stream format: N_hi, N_lo (16-bit word count N, big-endian), then N×4 data bytes (MSB first per word), then 1 checksum byte.
- The checksum is the XOR of all data bytes only; header bytes are excluded.
- States and transitions:
  - HDR_HI: accept N_hi → HDR_LO.
  - HDR_LO: accept N_lo.
    - If N > MAX_WORDS → ERROR.
    - Else if N == 0 → CSUM.
    - Else → DATA.
  - DATA: shift each byte into a 32-bit assembly register (new byte in bits [7:0]) and XOR it into the running checksum.
    - A 2-bit byte counter tracks position within the word.
    - On the 4th byte of a word, launch a write.
    - After the 4th byte of word N → CSUM.
  - CSUM: accept the checksum byte.
    - If it equals the running XOR → DONE.
    - Else → ERROR.
  - DONE: load_done=1, cpu_areset=0, in_ready=0. Terminal until reset.
  - ERROR: load_error=1, cpu_areset=1, in_ready=0. Terminal until reset.
- in_ready=1 in HDR_HI, HDR_LO, DATA and CSUM.
- Write addressing: word i (0-based) is written to BASE_ADDR + 4*i. Address arithmetic is 32-bit and wraps modulo 2^32.
- words_loaded increments by 1 with each imem_we pulse.
- A reset mid-load returns to HDR_HI and clears all counters, the checksum and the flags. Words already written stay in memory; the next stream overwrites them.

## Timing
- Reset values:
  - in_ready=1 (state HDR_HI).
  - imem_we=0, imem_addr=BASE_ADDR, imem_wd=0.
  - cpu_areset=1, load_done=0, load_error=0, words_loaded=0.
- Write latency: imem_we, imem_addr and imem_wd are registered. They are valid for exactly one cycle, on the cycle after the edge that accepted the word's 4th byte.
- No backpressure is needed during a write. in_ready stays 1, so back-to-back bytes load one byte per cycle and one word per 4 cycles.
- Flag timing:
  - load_done and cpu_areset deassertion appear on the edge that accepts a matching checksum byte. The final imem_we has already completed by that edge, or at the latest on the same edge.
  - load_error appears on the edge that accepts a bad checksum or a bad N_lo.
- cpu_areset is a registered output, so there are no glitches.

## Test plan
- Good load: stream 00 02 20 08 00 05 20 09 00 0A 0E →
  - imem_we pulses with (addr 0x0, wd 0x20080005), then (addr 0x4, wd 0x2009000A).
  - load_done=1, cpu_areset=0, words_loaded=2, in_ready=0.
- Bad checksum: same stream ending in 0F → same two writes, then load_error=1, cpu_areset stays 1, load_done=0, in_ready=0.
- Empty program: 00 00 00 → no imem_we pulse, load_done=1, cpu_areset=0, words_loaded=0.
- Overflow: 00 41 with MAX_WORDS=64 → load_error=1 on the N_lo edge, no writes. Further in_valid bytes are not accepted.
- Bubbles: good-load stream with in_valid randomly low between bytes, and in_valid high while in DONE → identical writes and flags, and no extra byte is consumed after DONE.
- Reset mid-load, with BASE_ADDR=0x100:
  - Stimulus: assert areset after 00 02 20 08 00 05 20, then send the full good-load stream.
  - Required: all outputs return to their reset values immediately. After the full stream, the writes go to 0x100 and 0x104 with the same data, and load_done=1.
